// File: rtl/l1_d_data_array_nway_if.sv
// Request/response bundle between the L1 D controller / L2 side and the N-way data array.
interface l1_d_data_array_nway_if #(
  parameter int LINE_W   = 512,
  parameter int WORD_W   = 32,
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 2
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int BE_W  = WORD_W / 8;

  logic              rd_en;
  logic [IDX_W-1:0]  rd_index;
  logic [WAY_W-1:0]  rd_way;
  logic [OFF_W-1:0]  rd_offset;
  logic              rd_valid;
  logic [WORD_W-1:0] rd_data;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_index;
  logic [WAY_W-1:0]  wr_way;
  logic [OFF_W-1:0]  wr_offset;
  logic [WORD_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic              wr_drop;

  logic              refill_en;
  logic [IDX_W-1:0]  refill_index;
  logic [WAY_W-1:0]  refill_way;
  logic [LINE_W-1:0] refill_data;

  logic              evict_en;
  logic [IDX_W-1:0]  evict_index;
  logic [WAY_W-1:0]  evict_way;
  logic              evict_valid;
  logic [LINE_W-1:0] evict_data;

  modport master (
    output rd_en, rd_index, rd_way, rd_offset,
    output wr_en, wr_index, wr_way, wr_offset, wr_data, wr_be,
    output refill_en, refill_index, refill_way, refill_data,
    output evict_en, evict_index, evict_way,
    input  rd_valid, rd_data, wr_drop, evict_valid, evict_data
  );

  modport slave (
    input  rd_en, rd_index, rd_way, rd_offset,
    input  wr_en, wr_index, wr_way, wr_offset, wr_data, wr_be,
    input  refill_en, refill_index, refill_way, refill_data,
    input  evict_en, evict_index, evict_way,
    output rd_valid, rd_data, wr_drop, evict_valid, evict_data
  );
endinterface

// File: rtl/l1_d_data_array_nway.sv
// N-way set-associative L1 D data array: registered word reads, byte-masked stores,
// full-line refills and full-line eviction reads. Read-first, no bypass.
module l1_d_data_array_nway #(
  parameter int LINE_W   = 512,
  parameter int WORD_W   = 32,
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 2
) (
  input  logic                    clk,
  input  logic                    nrst,
  l1_d_data_array_nway_if.slave   bus
);
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int OFF_W    = $clog2(LINE_W / 8);
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int BE_W     = WORD_W / 8;
  localparam int WSEL_LSB = $clog2(BE_W);
  localparam int WPL      = LINE_W / WORD_W;
  localparam int WSEL_W   = OFF_W - WSEL_LSB;

  typedef logic [WPL-1:0][WORD_W-1:0] line_words_t;

  logic [LINE_W-1:0] line_q [NUM_SETS][NUM_WAYS];
  line_words_t       rd_line;
  line_words_t       wr_mask;
  line_words_t       wr_rep;
  logic [WORD_W-1:0] be_bits;
  logic [WSEL_W-1:0] rd_word;
  logic [WSEL_W-1:0] wr_word;
  logic              same_line;

  logic              rd_valid_reg;
  logic [WORD_W-1:0] rd_data_reg;
  logic              evict_valid_reg;
  logic [LINE_W-1:0] evict_data_reg;
  logic              wr_drop_reg;
  logic              unused_offset_bits;

  assign rd_word = bus.rd_offset[OFF_W-1:WSEL_LSB];
  assign wr_word = bus.wr_offset[OFF_W-1:WSEL_LSB];
  assign rd_line = line_q[bus.rd_index][bus.rd_way];
  assign unused_offset_bits = ^{bus.rd_offset[WSEL_LSB-1:0], bus.wr_offset[WSEL_LSB-1:0]};

  // A refill and a store to the same line: the refill owns the line, the store is lost.
  assign same_line = bus.refill_en && bus.wr_en &&
                     (bus.refill_index == bus.wr_index) && (bus.refill_way == bus.wr_way);

  genvar gi, gw;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_be
      assign be_bits[gi*8 +: 8] = {8{bus.wr_be[gi]}};
    end

    for (gi = 0; gi < WPL; gi++) begin : g_mask
      assign wr_mask[gi] = (wr_word == WSEL_W'(gi)) ? be_bits : '0;
      assign wr_rep[gi]  = bus.wr_data;
    end

    for (gi = 0; gi < NUM_SETS; gi++) begin : g_set
      for (gw = 0; gw < NUM_WAYS; gw++) begin : g_way
        logic [LINE_W-1:0] line_reg;
        logic              refill_hit;
        logic              wr_hit;

        assign refill_hit = bus.refill_en && (bus.refill_index == IDX_W'(gi)) &&
                            (bus.refill_way == WAY_W'(gw));
        assign wr_hit     = bus.wr_en && (bus.wr_index == IDX_W'(gi)) &&
                            (bus.wr_way == WAY_W'(gw));

        always_ff @(posedge clk or negedge nrst) begin
          if (!nrst) begin
            line_reg <= '0;
          end else if (refill_hit) begin
            line_reg <= bus.refill_data;
          end else if (wr_hit) begin
            line_reg <= (line_reg & ~wr_mask) | (wr_rep & wr_mask);
          end
        end

        assign line_q[gi][gw] = line_reg;
      end
    end

    if (NUM_WAYS != (1 << WAY_W)) begin : g_way_chk
      a_rd_way:     assert property (@(posedge clk) disable iff (!nrst)
                      bus.rd_en |-> (int'(bus.rd_way) < NUM_WAYS));
      a_wr_way:     assert property (@(posedge clk) disable iff (!nrst)
                      bus.wr_en |-> (int'(bus.wr_way) < NUM_WAYS));
      a_refill_way: assert property (@(posedge clk) disable iff (!nrst)
                      bus.refill_en |-> (int'(bus.refill_way) < NUM_WAYS));
      a_evict_way:  assert property (@(posedge clk) disable iff (!nrst)
                      bus.evict_en |-> (int'(bus.evict_way) < NUM_WAYS));
    end
  endgenerate

  // Outputs sample the pre-write array contents, so same-cycle writes are not visible.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_valid_reg    <= 1'b0;
      rd_data_reg     <= '0;
      evict_valid_reg <= 1'b0;
      evict_data_reg  <= '0;
      wr_drop_reg     <= 1'b0;
    end else begin
      rd_valid_reg    <= bus.rd_en;
      evict_valid_reg <= bus.evict_en;
      wr_drop_reg     <= same_line;
      if (bus.rd_en) begin
        rd_data_reg <= rd_line[rd_word];
      end
      if (bus.evict_en) begin
        evict_data_reg <= line_q[bus.evict_index][bus.evict_way];
      end
    end
  end

  assign bus.rd_valid    = rd_valid_reg;
  assign bus.rd_data     = rd_data_reg;
  assign bus.evict_valid = evict_valid_reg;
  assign bus.evict_data  = evict_data_reg;
  assign bus.wr_drop     = wr_drop_reg;
endmodule

// File: tb/tb_l1_d_data_array_nway.sv
// Bench for l1_d_data_array_nway: directed vector table, eviction/reset sequences,
// and a randomized run against a word-level array model.
module tb_l1_d_data_array_nway;
  logic clk;
  logic nrst;

  l1_d_data_array_nway_if #(.LINE_W(512), .WORD_W(32), .NUM_SETS(64), .NUM_WAYS(2)) bus ();

  l1_d_data_array_nway #(.LINE_W(512), .WORD_W(32), .NUM_SETS(64), .NUM_WAYS(2)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd_en;
    logic [5:0]  rd_index;
    logic        rd_way;
    logic [5:0]  rd_offset;
    logic        wr_en;
    logic [5:0]  wr_index;
    logic        wr_way;
    logic [5:0]  wr_offset;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        refill_en;
    logic [5:0]  refill_index;
    logic        refill_way;
    logic [31:0] refill_base;
    logic        refill_inc;
    logic        exp_rd_valid;
    logic [31:0] exp_rd_data;
    logic        exp_wr_drop;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int n_tests;
  int n_fail;

  // Reference model: plain word array, refill replaces 16 words, store merges bytes.
  logic [31:0]  mem_m [64][2][16];
  logic [31:0]  exp_rd;
  logic [511:0] exp_ev;
  logic [511:0] line_v;

  logic        r_en, w_en, f_en, e_en, exp_drop;
  logic [5:0]  r_idx, w_idx, f_idx, e_idx, r_off, w_off;
  logic        r_way, w_way, f_way, e_way;
  logic [31:0] w_dat;
  logic [3:0]  w_be;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_en = 1'b0;       bus.rd_index = '0;     bus.rd_way = '0;     bus.rd_offset = '0;
    bus.wr_en = 1'b0;       bus.wr_index = '0;     bus.wr_way = '0;     bus.wr_offset = '0;
    bus.wr_data = '0;       bus.wr_be = '0;
    bus.refill_en = 1'b0;   bus.refill_index = '0; bus.refill_way = '0; bus.refill_data = '0;
    bus.evict_en = 1'b0;    bus.evict_index = '0;  bus.evict_way = '0;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 2; w++)
        for (int k = 0; k < 16; k++)
          mem_m[s][w][k] = 32'h0;
    exp_rd = 32'h0;
    exp_ev = '0;
  endtask

  task automatic evict_check(input string nm, input logic [5:0] idx, input logic way,
                             input logic [511:0] exp_line);
    idle();
    bus.evict_en = 1'b1; bus.evict_index = idx; bus.evict_way = way;
    tick();
    $display("[TB] evict set %0d way %0d -> valid %0b", idx, way, bus.evict_valid);
    chk({nm, "_valid"}, {511'd0, bus.evict_valid}, 512'd1);
    chk({nm, "_data"}, bus.evict_data, exp_line);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //          rd_en  idx  way  off     wr_en idx  way  off    data          be      rf_en idx  way  base           inc     exp_v exp_data       drop
    vecs[0]  = '{1'b1,6'd5,1'b1,6'h08, 1'b0,6'd0,1'b0,6'h00,32'h00000000,4'h0, 1'b0,6'd0,1'b0,32'h00000000,1'b0, 1'b1,32'h00000000,1'b0};
    vecs[1]  = '{1'b0,6'd0,1'b0,6'h00, 1'b0,6'd0,1'b0,6'h00,32'h00000000,4'h0, 1'b1,6'd3,1'b0,32'hA0000000,1'b1, 1'b0,32'h00000000,1'b0};
    vecs[2]  = '{1'b1,6'd3,1'b0,6'h3C, 1'b0,6'd0,1'b0,6'h00,32'h00000000,4'h0, 1'b0,6'd0,1'b0,32'h00000000,1'b0, 1'b1,32'hA000000F,1'b0};
    vecs[3]  = '{1'b1,6'd3,1'b1,6'h00, 1'b0,6'd0,1'b0,6'h00,32'h00000000,4'h0, 1'b0,6'd0,1'b0,32'h00000000,1'b0, 1'b1,32'h00000000,1'b0};
    vecs[4]  = '{1'b0,6'd0,1'b0,6'h00, 1'b1,6'd3,1'b0,6'h04,32'h11223344,4'h5, 1'b0,6'd0,1'b0,32'h00000000,1'b0, 1'b0,32'h00000000,1'b0};
    vecs[5]  = '{1'b1,6'd3,1'b0,6'h04, 1'b0,6'd0,1'b0,6'h00,32'h00000000,4'h0, 1'b0,6'd0,1'b0,32'h00000000,1'b0, 1'b1,32'hA0220044,1'b0};
    vecs[6]  = '{1'b0,6'd0,1'b0,6'h00, 1'b1,6'd7,1'b1,6'h00,32'h00000000,4'hF, 1'b1,6'd7,1'b1,32'hFFFFFFFF,1'b0, 1'b0,32'hA0220044,1'b1};
    vecs[7]  = '{1'b1,6'd7,1'b1,6'h00, 1'b0,6'd0,1'b0,6'h00,32'h00000000,4'h0, 1'b0,6'd0,1'b0,32'h00000000,1'b0, 1'b1,32'hFFFFFFFF,1'b0};
    vecs[8]  = '{1'b0,6'd0,1'b0,6'h00, 1'b1,6'd7,1'b0,6'h08,32'h12345678,4'hF, 1'b1,6'd7,1'b1,32'hFFFFFFFF,1'b0, 1'b0,32'hFFFFFFFF,1'b0};
    vecs[9]  = '{1'b1,6'd7,1'b0,6'h08, 1'b0,6'd0,1'b0,6'h00,32'h00000000,4'h0, 1'b0,6'd0,1'b0,32'h00000000,1'b0, 1'b1,32'h12345678,1'b0};
    vecs[10] = '{1'b1,6'd3,1'b0,6'h3C, 1'b1,6'd3,1'b0,6'h3C,32'hDEADBEEF,4'hF, 1'b0,6'd0,1'b0,32'h00000000,1'b0, 1'b1,32'hA000000F,1'b0};
    vecs[11] = '{1'b1,6'd3,1'b0,6'h3C, 1'b0,6'd0,1'b0,6'h00,32'h00000000,4'h0, 1'b0,6'd0,1'b0,32'h00000000,1'b0, 1'b1,32'hDEADBEEF,1'b0};
    vecs[12] = '{1'b0,6'd0,1'b0,6'h00, 1'b1,6'd3,1'b0,6'h3C,32'h00000000,4'h0, 1'b0,6'd0,1'b0,32'h00000000,1'b0, 1'b0,32'hDEADBEEF,1'b0};
    vecs[13] = '{1'b1,6'd3,1'b0,6'h3F, 1'b0,6'd0,1'b0,6'h00,32'h00000000,4'h0, 1'b0,6'd0,1'b0,32'h00000000,1'b0, 1'b1,32'hDEADBEEF,1'b0};
    vecs[14] = '{1'b1,6'd7,1'b1,6'h20, 1'b0,6'd0,1'b0,6'h00,32'h00000000,4'h0, 1'b0,6'd0,1'b0,32'h00000000,1'b0, 1'b1,32'hFFFFFFFF,1'b0};

    // Reset state
    nrst = 1'b0;
    idle();
    repeat (3) tick();
    $display("[TB] reset asserted");
    chk("reset_rd_valid",    {511'd0, bus.rd_valid},    512'd0);
    chk("reset_rd_data",     {480'd0, bus.rd_data},     512'd0);
    chk("reset_evict_valid", {511'd0, bus.evict_valid}, 512'd0);
    chk("reset_evict_data",  bus.evict_data,            512'd0);
    chk("reset_wr_drop",     {511'd0, bus.wr_drop},     512'd0);
    nrst = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      bus.rd_en = vecs[i].rd_en;         bus.rd_index = vecs[i].rd_index;
      bus.rd_way = vecs[i].rd_way;       bus.rd_offset = vecs[i].rd_offset;
      bus.wr_en = vecs[i].wr_en;         bus.wr_index = vecs[i].wr_index;
      bus.wr_way = vecs[i].wr_way;       bus.wr_offset = vecs[i].wr_offset;
      bus.wr_data = vecs[i].wr_data;     bus.wr_be = vecs[i].wr_be;
      bus.refill_en = vecs[i].refill_en; bus.refill_index = vecs[i].refill_index;
      bus.refill_way = vecs[i].refill_way;
      for (int k = 0; k < 16; k++)
        line_v[k*32 +: 32] = vecs[i].refill_inc ? (vecs[i].refill_base + 32'(k)) : vecs[i].refill_base;
      bus.refill_data = line_v;
      tick();
      $display("[TB] vec %0d: rd_valid %0b rd_data %08h wr_drop %0b", i, bus.rd_valid, bus.rd_data, bus.wr_drop);
      chk($sformatf("vec%0d_rd_valid", i), {511'd0, bus.rd_valid}, {511'd0, vecs[i].exp_rd_valid});
      chk($sformatf("vec%0d_rd_data", i),  {480'd0, bus.rd_data},  {480'd0, vecs[i].exp_rd_data});
      chk($sformatf("vec%0d_wr_drop", i),  {511'd0, bus.wr_drop},  {511'd0, vecs[i].exp_wr_drop});
      idle();
    end

    // Eviction of the refilled/merged line, with a concurrent read of the other way
    for (int k = 0; k < 16; k++) line_v[k*32 +: 32] = 32'hA0000000 + 32'(k);
    line_v[1*32 +: 32]  = 32'hA0220044;
    line_v[15*32 +: 32] = 32'hDEADBEEF;
    idle();
    bus.evict_en = 1'b1; bus.evict_index = 6'd3; bus.evict_way = 1'b0;
    bus.rd_en = 1'b1;    bus.rd_index = 6'd3;    bus.rd_way = 1'b1; bus.rd_offset = 6'h10;
    tick();
    $display("[TB] evict set 3 way 0 with read set 3 way 1");
    chk("ev3_valid",   {511'd0, bus.evict_valid}, 512'd1);
    chk("ev3_data",    bus.evict_data, line_v);
    chk("ev3_rd_valid", {511'd0, bus.rd_valid}, 512'd1);
    chk("ev3_rd_data", {480'd0, bus.rd_data}, 512'd0);
    idle();
    tick();
    $display("[TB] idle after evict");
    chk("ev_pulse_end", {511'd0, bus.evict_valid}, 512'd0);
    chk("ev_hold",      bus.evict_data, line_v);

    evict_check("ev7w1", 6'd7, 1'b1, {512{1'b1}});
    line_v = '0;
    line_v[2*32 +: 32] = 32'h12345678;
    evict_check("ev7w0", 6'd7, 1'b0, line_v);

    // Randomized run against the model, from a clean reset
    nrst = 1'b0;
    idle();
    tick();
    nrst = 1'b1;
    model_clear();
    tick();
    for (int c = 0; c < 300; c++) begin
      r_en  = 1'($urandom_range(1));  r_idx = 6'($urandom_range(3)); r_way = 1'($urandom_range(1));
      r_off = 6'($urandom_range(63));
      w_en  = 1'($urandom_range(1));  w_idx = 6'($urandom_range(3)); w_way = 1'($urandom_range(1));
      w_off = 6'($urandom_range(63)); w_dat = $urandom;              w_be  = 4'($urandom_range(15));
      f_en  = ($urandom_range(3) == 0); f_idx = 6'($urandom_range(3)); f_way = 1'($urandom_range(1));
      e_en  = 1'($urandom_range(1));  e_idx = 6'($urandom_range(3)); e_way = 1'($urandom_range(1));
      for (int k = 0; k < 16; k++) line_v[k*32 +: 32] = $urandom;

      bus.rd_en = r_en;  bus.rd_index = r_idx;  bus.rd_way = r_way;  bus.rd_offset = r_off;
      bus.wr_en = w_en;  bus.wr_index = w_idx;  bus.wr_way = w_way;  bus.wr_offset = w_off;
      bus.wr_data = w_dat; bus.wr_be = w_be;
      bus.refill_en = f_en; bus.refill_index = f_idx; bus.refill_way = f_way; bus.refill_data = line_v;
      bus.evict_en = e_en; bus.evict_index = e_idx; bus.evict_way = e_way;

      if (r_en) exp_rd = mem_m[r_idx][r_way][r_off[5:2]];
      if (e_en) for (int k = 0; k < 16; k++) exp_ev[k*32 +: 32] = mem_m[e_idx][e_way][k];
      exp_drop = f_en && w_en && (f_idx == w_idx) && (f_way == w_way);

      tick();
      $display("[TB] rnd %0d: rd %0b/%08h ev %0b wr_drop %0b", c, bus.rd_valid, bus.rd_data, bus.evict_valid, bus.wr_drop);
      chk($sformatf("rnd%0d_rd_valid", c), {511'd0, bus.rd_valid},    {511'd0, r_en});
      chk($sformatf("rnd%0d_rd_data", c),  {480'd0, bus.rd_data},     {480'd0, exp_rd});
      chk($sformatf("rnd%0d_ev_valid", c), {511'd0, bus.evict_valid}, {511'd0, e_en});
      chk($sformatf("rnd%0d_ev_data", c),  bus.evict_data,            exp_ev);
      chk($sformatf("rnd%0d_wr_drop", c),  {511'd0, bus.wr_drop},     {511'd0, exp_drop});

      if (w_en && !exp_drop)
        for (int b = 0; b < 4; b++)
          if (w_be[b]) mem_m[w_idx][w_way][w_off[5:2]][b*8 +: 8] = w_dat[b*8 +: 8];
      if (f_en)
        for (int k = 0; k < 16; k++) mem_m[f_idx][f_way][k] = line_v[k*32 +: 32];
    end

    // Reset in the middle of back-to-back reads plus an eviction
    idle();
    bus.wr_en = 1'b1; bus.wr_index = 6'd3; bus.wr_way = 1'b0; bus.wr_offset = 6'h00;
    bus.wr_data = 32'hCAFEF00D; bus.wr_be = 4'hF;
    tick();
    idle();
    bus.rd_en = 1'b1; bus.rd_index = 6'd3; bus.rd_way = 1'b0; bus.rd_offset = 6'h00;
    bus.evict_en = 1'b1; bus.evict_index = 6'd3; bus.evict_way = 1'b0;
    tick();
    $display("[TB] back-to-back read 1: %0b/%08h", bus.rd_valid, bus.rd_data);
    chk("mid_rd_valid", {511'd0, bus.rd_valid}, 512'd1);
    chk("mid_rd_data",  {480'd0, bus.rd_data},  {480'd0, 32'hCAFEF00D});
    #2;
    nrst = 1'b0;
    #1;
    $display("[TB] reset mid-operation: rd %0b ev %0b", bus.rd_valid, bus.evict_valid);
    chk("mid_rst_rd_valid", {511'd0, bus.rd_valid},    512'd0);
    chk("mid_rst_ev_valid", {511'd0, bus.evict_valid}, 512'd0);
    chk("mid_rst_rd_data",  {480'd0, bus.rd_data},     512'd0);
    chk("mid_rst_ev_data",  bus.evict_data,            512'd0);
    tick();
    nrst = 1'b1;
    tick();
    tick();
    $display("[TB] read after reset: %0b/%08h", bus.rd_valid, bus.rd_data);
    chk("post_rst_rd_valid", {511'd0, bus.rd_valid}, 512'd1);
    chk("post_rst_rd_data",  {480'd0, bus.rd_data},  512'd0);
    chk("post_rst_ev_data",  bus.evict_data,         512'd0);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
